// File: rtl/ssram_pkg.sv
// Shared constants and types for the arbitrated single-port SRAM.
package ssram_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam int unsigned DEF_AW    = 15;
    localparam int unsigned DEF_DW    = 32;
    localparam int unsigned DEF_DEPTH = 32768;

    // Which port received the most recent grant.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

endpackage

// File: rtl/ssram_bank.sv
// Single-port byte-enabled storage with a registered (1-cycle) read.
module ssram_bank #(
    parameter int unsigned AW    = 15,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 32768
) (
    input  logic            clk,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [AW-1:0]   adr_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   din_i,
    output logic [DW-1:0]   dout_o
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [IW-1:0] idx;

    // Caller only enables in-range addresses, so the low bits are the index.
    assign idx    = IW'(adr_i);
    assign dout_o = rdata_q;

    // Byte-masked write or registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx][b*8 +: 8] <= din_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

endmodule

// File: rtl/ssram_arb.sv
// Two-port front end arbitrating onto one single-port SRAM bank.
module ssram_arb
    import ssram_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_req,
    input  logic            b_req,
    input  logic            a_we,
    input  logic            b_we,
    input  logic [AW-1:0]   a_adr,
    input  logic [AW-1:0]   b_adr,
    input  logic [DW/8-1:0] a_be,
    input  logic [DW/8-1:0] b_be,
    input  logic [DW-1:0]   a_din,
    input  logic [DW-1:0]   b_din,
    output logic            a_gnt,
    output logic            b_gnt,
    output logic [DW-1:0]   a_dout,
    output logic [DW-1:0]   b_dout,
    output logic            a_dvld,
    output logic            b_dvld,
    output logic            a_err,
    output logic            b_err
);

    last_e           last_q, last_d;
    logic            sel_we;
    logic [AW-1:0]   sel_adr;
    logic [DW/8-1:0] sel_be;
    logic [DW-1:0]   sel_din;
    logic            in_rng;
    logic            bank_en;
    logic [DW-1:0]   bank_rdata;
    logic [1:0]      gnt_v;
    logic [1:0]      rd_q;
    logic [1:0]      oor_q;
    logic [1:0]      err_q;
    logic [DW-1:0]   hold_q [2];
    logic [DW-1:0]   dout_c [2];

    // Last-granted pointer; B after reset so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= LAST_B;
        end else begin
            last_q <= last_d;
        end
    end

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        last_d = last_q;
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        if (rst) begin
            if (ARB_MODE == ARB_FIXED) begin
                a_gnt = a_req;
                b_gnt = b_req & ~a_req;
            end else if (a_req && b_req) begin
                a_gnt = (last_q == LAST_B);
                b_gnt = (last_q == LAST_A);
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
            if (a_gnt) begin
                last_d = LAST_A;
            end else if (b_gnt) begin
                last_d = LAST_B;
            end
        end
    end

    assign gnt_v   = {b_gnt, a_gnt};
    assign sel_we  = b_gnt ? b_we  : a_we;
    assign sel_adr = b_gnt ? b_adr : a_adr;
    assign sel_be  = b_gnt ? b_be  : a_be;
    assign sel_din = b_gnt ? b_din : a_din;
    assign in_rng  = 32'(sel_adr) < 32'(DEPTH);
    assign bank_en = (a_gnt | b_gnt) & in_rng;

    ssram_bank #(
        .AW   (AW),
        .DW   (DW),
        .DEPTH(DEPTH)
    ) u_bank (
        .clk   (clk),
        .en_i  (bank_en),
        .we_i  (sel_we),
        .adr_i (sel_adr),
        .be_i  (sel_be),
        .din_i (sel_din),
        .dout_o(bank_rdata)
    );

    // Per-port flags for the cycle after a grant: read valid, out-of-range read, error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q  <= 2'b00;
            oor_q <= 2'b00;
            err_q <= 2'b00;
        end else begin
            rd_q  <= gnt_v & {2{~sel_we}};
            oor_q <= gnt_v & {2{~sel_we & ~in_rng}};
            err_q <= gnt_v & {2{~in_rng}};
        end
    end

    // Read data: fresh bank word (or zero when out of range) on dvld, else held value.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            dout_c[p] = hold_q[p];
            if (rd_q[p]) begin
                dout_c[p] = oor_q[p] ? '0 : bank_rdata;
            end
        end
    end

    // Holds the last delivered read word per port.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (!rst) begin
                hold_q[p] <= '0;
            end else begin
                hold_q[p] <= dout_c[p];
            end
        end
    end

    assign a_dout = rst ? dout_c[0] : '0;
    assign b_dout = rst ? dout_c[1] : '0;
    assign a_dvld = rst & rd_q[0];
    assign b_dvld = rst & rd_q[1];
    assign a_err  = rst & err_q[0];
    assign b_err  = rst & err_q[1];

endmodule

// File: tb/tb_ssram_arb.sv
// Directed bench for ssram_arb: round-robin instance (DEPTH=1000) and fixed-priority instance.
module tb_ssram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, b_req, a_we, b_we;
    logic [14:0] a_adr, b_adr;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_din, b_din;

    logic        a_gnt, b_gnt, a_dvld, b_dvld, a_err, b_err;
    logic [31:0] a_dout, b_dout;
    logic        fa_gnt, fb_gnt, fa_dvld, fb_dvld, fa_err, fb_err;
    logic [31:0] fa_dout, fb_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssram_arb #(.AW(15), .DW(32), .DEPTH(1000), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_adr(a_adr), .b_adr(b_adr), .a_be(a_be), .b_be(b_be),
        .a_din(a_din), .b_din(b_din),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_dout(a_dout), .b_dout(b_dout),
        .a_dvld(a_dvld), .b_dvld(b_dvld), .a_err(a_err), .b_err(b_err)
    );

    ssram_arb #(.AW(15), .DW(32), .DEPTH(32768), .ARB_MODE(1)) u_fx (
        .clk(clk), .rst(rst),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_adr(a_adr), .b_adr(b_adr), .a_be(a_be), .b_be(b_be),
        .a_din(a_din), .b_din(b_din),
        .a_gnt(fa_gnt), .b_gnt(fb_gnt), .a_dout(fa_dout), .b_dout(fb_dout),
        .a_dvld(fa_dvld), .b_dvld(fb_dvld), .a_err(fa_err), .b_err(fb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One access on a single port: check its grant, then return one cycle later
    // with the request dropped, positioned to check dvld/dout/err.
    task automatic acc(input bit pb, input bit we, input logic [14:0] adr,
                       input logic [3:0] be, input logic [31:0] din, input string tag);
        if (!pb) begin
            a_req = 1'b1; a_we = we; a_adr = adr; a_be = be; a_din = din;
        end else begin
            b_req = 1'b1; b_we = we; b_adr = adr; b_be = be; b_din = din;
        end
        #1;
        chk({tag, "_gnt"}, 32'(pb ? b_gnt : a_gnt), 32'd1);
        cyc();
        a_req = 1'b0;
        b_req = 1'b0;
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_adr = '0;   b_adr = '0;   a_be = '0;   b_be = '0;
        a_din = '0;   b_din = '0;
        repeat (2) cyc();

        // Reset: requests present but nothing granted, outputs quiet.
        chk("rst_a_gnt",  32'(a_gnt),  32'd0);
        chk("rst_b_gnt",  32'(b_gnt),  32'd0);
        chk("rst_a_dvld", 32'(a_dvld), 32'd0);
        chk("rst_a_err",  32'(a_err),  32'd0);
        chk("rst_a_dout", a_dout,      32'd0);
        chk("rst_b_dout", b_dout,      32'd0);
        chk("rst_fx_a_gnt", 32'(fa_gnt), 32'd0);

        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b1;
        cyc();

        // Both requesting for 6 cycles: RR alternates starting with A; fixed always A.
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_a_gnt%0d", i), 32'(a_gnt),  32'((i % 2) == 0));
            chk($sformatf("rr_b_gnt%0d", i), 32'(b_gnt),  32'((i % 2) == 1));
            chk($sformatf("fx_a_gnt%0d", i), 32'(fa_gnt), 32'd1);
            chk($sformatf("fx_b_gnt%0d", i), 32'(fb_gnt), 32'd0);
            cyc();
        end
        a_req = 1'b0; b_req = 1'b0;
        cyc();

        // Write on A, read back on B with latency 1, then dout holds.
        acc(1'b0, 1'b1, 15'd5, 4'hF, 32'hDEADBEEF, "wrA5");
        chk("wrA5_dvld", 32'(a_dvld), 32'd0);
        chk("wrA5_err",  32'(a_err),  32'd0);
        acc(1'b1, 1'b0, 15'd5, 4'h0, 32'h0, "rdB5");
        chk("rdB5_dvld", 32'(b_dvld), 32'd1);
        chk("rdB5_dout", b_dout,      32'hDEADBEEF);
        cyc();
        chk("holdB_dvld", 32'(b_dvld), 32'd0);
        chk("holdB_dout", b_dout,      32'hDEADBEEF);

        // Partial byte write merges into the preloaded word.
        acc(1'b0, 1'b1, 15'd9, 4'hF, 32'h11223344, "pre9");
        acc(1'b0, 1'b1, 15'd9, 4'h5, 32'hAABBCCDD, "be5");
        acc(1'b1, 1'b0, 15'd9, 4'h0, 32'h0, "rdB9");
        chk("rdB9_dout", b_dout, 32'h11BB33DD);
        // be=0 write is still granted but leaves memory alone.
        acc(1'b0, 1'b1, 15'd9, 4'h0, 32'hFFFFFFFF, "be0");
        acc(1'b0, 1'b0, 15'd9, 4'h0, 32'h0, "rdA9");
        chk("rdA9_dvld", 32'(a_dvld), 32'd1);
        chk("rdA9_dout", a_dout,      32'h11BB33DD);

        // Tie after an A grant: B wins; A's address changes while waiting.
        a_req = 1'b1; a_we = 1'b0; a_adr = 15'd5;
        b_req = 1'b1; b_we = 1'b0; b_adr = 15'd9;
        #1;
        chk("tie_b_gnt", 32'(b_gnt), 32'd1);
        chk("tie_a_gnt", 32'(a_gnt), 32'd0);
        cyc();
        b_req = 1'b0;
        a_adr = 15'd9;
        #1;
        chk("tie2_a_gnt", 32'(a_gnt),  32'd1);
        chk("tie2_b_dout", b_dout,     32'h11BB33DD);
        cyc();
        a_req = 1'b0;
        #1;
        chk("late_adr_dvld", 32'(a_dvld), 32'd1);
        chk("late_adr_dout", a_dout,      32'h11BB33DD);

        // Out-of-range accesses.
        acc(1'b0, 1'b1, 15'd0, 4'hF, 32'h12345678, "wr0");
        acc(1'b0, 1'b0, 15'd1000, 4'h0, 32'h0, "oorRd");
        chk("oorRd_dvld", 32'(a_dvld), 32'd1);
        chk("oorRd_dout", a_dout,      32'd0);
        chk("oorRd_err",  32'(a_err),  32'd1);
        cyc();
        chk("oorRd_err_pulse", 32'(a_err), 32'd0);
        acc(1'b1, 1'b1, 15'd1000, 4'hF, 32'hFFFFFFFF, "oorWr");
        chk("oorWr_err",  32'(b_err),  32'd1);
        chk("oorWr_dvld", 32'(b_dvld), 32'd0);
        acc(1'b0, 1'b0, 15'd0, 4'h0, 32'h0, "rd0");
        chk("rd0_dout", a_dout,     32'h12345678);
        chk("rd0_err",  32'(a_err), 32'd0);

        // Reset in the cycle after a read grant suppresses dvld; memory survives.
        a_req = 1'b1; a_we = 1'b0; a_adr = 15'd5;
        #1;
        chk("rstrd_gnt", 32'(a_gnt), 32'd1);
        cyc();
        a_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstrd_dvld", 32'(a_dvld), 32'd0);
        chk("rstrd_dout", a_dout,      32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        acc(1'b0, 1'b0, 15'd5, 4'h0, 32'h0, "postrst");
        chk("postrst_dvld", 32'(a_dvld), 32'd1);
        chk("postrst_dout", a_dout,      32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
